// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a big-endian word-wide data memory.
// Sub-word stores are done as read-modify-write. Memory strobes, write data and address
// are registered so the level-sensitive write enable never glitches.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_w_data,
  output logic        Mem_w,
  output logic        Mem_r,
  input  logic [31:0] Mem_r_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_w_data_q, mem_w_data_d;
  logic        mem_w_q, mem_w_d;
  logic        mem_r_q, mem_r_d;

  logic        req_err;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Address bits above the memory size alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS];

  assign req_err = (req_size == 2'd3) ||
                   ((req_size == SzHalf) && req_addr[0]) ||
                   ((req_size == SzWord) && (req_addr[1:0] != 2'b00));

  // Lane merge of store data into the word just read, and extension of loaded data.
  always_comb begin
    merged_word = Mem_r_data;
    load_byte   = 8'd0;
    load_half   = 16'd0;
    load_data   = rbuf_q;
    if (size_q == SzByte) begin
      unique case (off_q)
        2'd0: merged_word[31:24] = wdata_q[7:0];
        2'd1: merged_word[23:16] = wdata_q[7:0];
        2'd2: merged_word[15:8]  = wdata_q[7:0];
        default: merged_word[7:0] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged_word[15:0] = wdata_q;
    end else begin
      merged_word[31:16] = wdata_q;
    end

    unique case (off_q)
      2'd0: load_byte = rbuf_q[31:24];
      2'd1: load_byte = rbuf_q[23:16];
      2'd2: load_byte = rbuf_q[15:8];
      default: load_byte = rbuf_q[7:0];
    endcase
    load_half = off_q[1] ? rbuf_q[15:0] : rbuf_q[31:16];

    if (size_q == SzByte) begin
      load_data = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
    end else if (size_q == SzHalf) begin
      load_data = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
    end
  end

  // Next-state logic; memory strobes are set only on the transition into RD/WR.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rbuf_d       = rbuf_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    mem_w_d      = 1'b0;
    mem_r_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          uns_d      = req_unsigned;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          err_d      = req_err;
          mem_addr_d = '0;
          mem_addr_d[ADDR_BITS-1:2] = req_addr[ADDR_BITS-1:2];
          if (req_err) begin
            state_d = StResp;
          end else if (!req_we || (req_size != SzWord)) begin
            state_d = StRd;
            mem_r_d = 1'b1;
          end else begin
            state_d      = StWr;
            mem_w_d      = 1'b1;
            mem_w_data_d = req_wdata;
          end
        end
      end
      StRd: begin
        rbuf_d = Mem_r_data;
        if (we_q) begin
          state_d      = StWr;
          mem_w_d      = 1'b1;
          mem_w_data_d = merged_word;
        end else begin
          state_d = StResp;
        end
      end
      StWr: begin
        state_d = StResp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      wdata_q      <= 16'd0;
      err_q        <= 1'b0;
      rbuf_q       <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_w_data_q <= 32'd0;
      mem_w_q      <= 1'b0;
      mem_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rbuf_q       <= rbuf_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_w_q      <= mem_w_d;
      mem_r_q      <= mem_r_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = (state_q == StResp) && err_q;
  assign resp_rdata = ((state_q == StResp) && !err_q && !we_q) ? load_data : 32'd0;
  assign Mem_addr   = mem_addr_q;
  assign Mem_w_data = mem_w_data_q;
  assign Mem_w      = mem_w_q;
  assign Mem_r      = mem_r_q;

endmodule
